uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

UART receiver that turns the asynchronous serial line into parallel bytes. It samples at 16x the baud rate and sits directly upstream of the UART-to-ALU interface, which consumes `o_data` on each `o_rxDone` pulse. Bytes are framed as one start bit, `NB_DATA` data bits sent LSB first, no parity, and a stop interval of `NB_STOP` ticks. Frames with a bad stop bit are flagged and dropped.

## Interface
- `NB_DATA`, default 8: data bits per frame.
- `NB_STOP`, default 16: stop-interval length in ticks. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- `clk`, input, 1: system clock.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_tick`, input, 1: one-clk strobe at 16x baud, from the baud generator.
- `i_rx`, input, 1: serial line, asynchronous, idles high.
- `o_data`, output, `NB_DATA`: last correctly framed byte. Held until the next good frame.
- `o_rxDone`, output, 1: one-clk pulse when `o_data` has been updated.
- `o_frame_err`, output, 1: one-clk pulse when the stop bit is sampled low.

## Operation
- Input synchronizer:
  - `i_rx` passes through 2 flops, both reset to 1, giving `rx_s`.
  - All decisions use `rx_s`.
- Internal registers:
  - `state`.
  - Tick counter `s`, wide enough to hold `max(15, NB_STOP-1)`.
  - Bit counter `n`, range 0..`NB_DATA-1`.
  - Shift register `shreg`, `NB_DATA` bits.
- Registers advance only on clocks where `i_tick`=1. The exception is IDLE, which reacts on any clock.
- States:
  - IDLE:
    - When `rx_s`==0, go to START and set `s`=0.
  - START:
    - On each tick, if `s`==7: when `rx_s`==0, go to DATA with `s`=0 and `n`=0. Otherwise treat it as a glitch and go to IDLE.
    - Otherwise `s++`.
  - DATA:
    - On each tick, if `s`==15: set `s`=0 and `shreg` = {`rx_s`, `shreg[NB_DATA-1:1]`}.
    - Then, if `n`==`NB_DATA-1`, go to STOP; otherwise `n++`.
    - Otherwise `s++`.
  - STOP:
    - On each tick, if `s`==`NB_STOP-1`: go to IDLE. If `rx_s`==1, load `o_data` from `shreg` and pulse `o_rxDone`. Otherwise pulse `o_frame_err` and leave `o_data` unchanged.
    - Otherwise `s++`.
- `o_rxDone` and `o_frame_err` are registered and mutually exclusive. Each is high for exactly one clk.
- The sampled data bits land at mid-bit, because START consumed half a bit.
- Entering IDLE at mid-stop leaves half a bit for the receiver to catch the next start edge.

## Timing
- Reset values: `o_data`=0, `o_rxDone`=0, `o_frame_err`=0, state IDLE, sync flops=1, `s`=`n`=`shreg`=0.
- Asserting reset mid-frame aborts the frame immediately. No pulse is emitted, then or after release.
- The first falling edge after reset release is a valid start.
- The falling edge on `i_rx` reaches `rx_s` 2 clks later, and START is entered on the next clk.
- Counting ticks from entering START, with `NB_STOP`=16:
  - mid start bit: tick 8
  - data bit k: tick 8+16(k+1)
  - stop sample: tick 8+16·`NB_DATA`+`NB_STOP` (152 for defaults)
- The output pulse appears the clk after the stop-sample tick. `o_data` is valid in that same clk and stays stable afterwards.
- Back-to-back frames with no idle gap are received without loss.
- Line held low (break): each frame time yields one `o_frame_err` and no `o_rxDone`. The receiver restarts immediately from IDLE.
- `i_tick` absent: the FSM freezes in its current state, except for IDLE edge detection.
- Simultaneous `i_tick` and state decision resolve on the same clk; no tick is lost.

## Test plan
- Good frame: send 0xA5 at 16 clks/tick with 1 stop bit. Expect `o_data`=0xA5 and one `o_rxDone` pulse 152 ticks after START, with `o_frame_err`=0.
- Back-to-back: send 0x00 immediately followed by 0xFF, no idle gap. Expect two `o_rxDone` pulses with `o_data`=0x00 then 0xFF.
- Glitch: drive `i_rx` low for 4 ticks, then high; 20 ticks later send 0x3C.
  - Expect no pulse for the glitch.
  - Expect exactly one `o_rxDone` with `o_data`=0x3C.
- Frame error:
  - Receive 0x12 successfully.
  - Then send 0x55 with the stop bit low.
  - Expect one `o_frame_err` pulse, no `o_rxDone`, and `o_data` still 0x12.
- Reset mid-frame: assert `i_rst_n`=0 during data bit 4 of 0xC3.
  - Expect all outputs 0 and no pulse.
  - After release, with the line idle for 1 bit, send 0x81 and expect `o_data`=0x81.
- Two stop bits: with `NB_STOP`=32, send 0x7E, and check the stop-sample timing.
  - Expect the pulse 168 ticks after START.
  - Expect a following frame to be received correctly when sent right after the 2nd stop bit.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x-oversampled UART receiver (start bit, NB_DATA data bits LSB first, no parity,
// NB_STOP-tick stop interval). Good frames update o_data with an o_rxDone pulse; a low stop bit pulses o_frame_err.
module uart_rx_sampler #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_STOP = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rxDone,
  output logic               o_frame_err
);

  localparam int unsigned S_MAX = ((NB_STOP - 1) > 15) ? (NB_STOP - 1) : 15;
  localparam int unsigned SW    = $clog2(S_MAX + 1);
  localparam int unsigned NW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(NB_STOP - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [NW-1:0]       n_q, n_d;
  logic [NB_DATA-1:0]  shreg_q, shreg_d;
  logic [NB_DATA-1:0]  data_d;
  logic                done_d, err_d;
  logic                rx_meta, rx_s;

  // Two-flop synchronizer; idle-high reset value keeps a reset line from looking like a start edge.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shreg_q     <= '0;
      o_data      <= '0;
      o_rxDone    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      shreg_q     <= shreg_d;
      o_data      <= data_d;
      o_rxDone    <= done_d;
      o_frame_err <= err_d;
    end
  end

  // IDLE watches every clock; the other states only move on ticks.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    data_d  = o_data;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (i_tick) begin
          if (s_q == S_HALF) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            shreg_d = {rx_s, shreg_q[NB_DATA-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            if (rx_s) begin
              data_d = shreg_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: one instance with 1 stop bit, one with 2 stop bits, 16 clks per tick.
module tb_uart_rx_sampler;

  localparam int unsigned CLKS_PER_TICK = 16;
  localparam int          NV            = 5;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_tick = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       done_a, done_b, err_a, err_b;

  always #5 clk = ~clk;

  uart_rx_sampler #(.NB_DATA(8), .NB_STOP(16)) dut_a (
    .clk(clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_rx(rx_a),
    .o_data(data_a), .o_rxDone(done_a), .o_frame_err(err_a)
  );

  uart_rx_sampler #(.NB_DATA(8), .NB_STOP(32)) dut_b (
    .clk(clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_rx(rx_b),
    .o_data(data_b), .o_rxDone(done_b), .o_frame_err(err_b)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         exp_data;
    int         exp_done;
    int         exp_err;
    int         exp_lat;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  logic [3:0] tick_div = 4'd0;
  int   tick_cnt = 0;
  int   start_tick_a = 0;
  int   start_tick_b = 0;
  int   err_cnt_a = 0;
  int   err_cnt_b = 0;
  int   err_lat_a = 0;
  int   excl_viol = 0;
  logic [7:0] dq_a[$];
  logic [7:0] dq_b[$];
  int   lq_a[$];
  int   lq_b[$];
  vec_t vecs [NV];

  // Tick strobe: one clk high every 16 clks, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tick_div = tick_div + 4'd1;
      i_tick   = (tick_div == 4'd15);
    end
  end

  always @(posedge clk) begin
    if (i_tick) tick_cnt <= tick_cnt + 1;
  end

  // Pulse monitor: logs every received byte with its tick latency from START.
  always @(negedge clk) begin
    if (done_a) begin
      dq_a.push_back(data_a);
      lq_a.push_back(tick_cnt - start_tick_a);
    end
    if (done_b) begin
      dq_b.push_back(data_b);
      lq_b.push_back(tick_cnt - start_tick_b);
    end
    if (err_a) begin
      err_cnt_a <= err_cnt_a + 1;
      err_lat_a <= tick_cnt - start_tick_a;
    end
    if (err_b) err_cnt_b <= err_cnt_b + 1;
    if ((done_a && err_a) || (done_b && err_b)) excl_viol <= excl_viol + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic set_line(input bit line, input logic v);
    if (line) rx_b = v;
    else      rx_a = v;
  endtask

  task automatic drive_bit(input bit line, input logic v, input int nticks);
    set_line(line, v);
    repeat (nticks * CLKS_PER_TICK) @(negedge clk);
  endtask

  // Lands on the falling edge two clks before a tick edge, so the tick that
  // coincides with START entry is not counted and all frames share one phase.
  task automatic align();
    do @(posedge clk); while (tick_div != 4'd12);
    @(negedge clk);
  endtask

  task automatic mark_start(input bit line);
    if (line) start_tick_b = tick_cnt + 1;
    else      start_tick_a = tick_cnt + 1;
  endtask

  task automatic send_frame(input bit line, input logic [7:0] d, input logic stop_ok,
                            input int stop_ticks, input bit b2b);
    if (!b2b) align();
    mark_start(line);
    drive_bit(line, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(line, d[i], 16);
    drive_bit(line, stop_ok, stop_ticks);
    set_line(line, 1'b1);
  endtask

  initial begin
    int d0, e0, d1;
    logic [7:0] c3;

    vecs[0] = '{8'hA5, 1'b1, 32'h0A5, 1, 0, 152};
    vecs[1] = '{8'h00, 1'b1, 32'h000, 1, 0, 152};
    vecs[2] = '{8'hFF, 1'b1, 32'h0FF, 1, 0, 152};
    vecs[3] = '{8'h12, 1'b1, 32'h012, 1, 0, 152};
    vecs[4] = '{8'h55, 1'b0, 32'h012, 0, 1, 152};

    repeat (5) @(negedge clk);
    check("reset_data_a", int'(data_a), 0);
    check("reset_done_a", int'(done_a), 0);
    check("reset_err_a", int'(err_a), 0);
    check("reset_data_b", int'(data_b), 0);
    i_rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_done_a", int'(done_a), 0);

    // Single frames, including a bad stop bit that must leave o_data alone.
    for (int i = 0; i < NV; i++) begin
      d0 = dq_a.size();
      e0 = err_cnt_a;
      send_frame(1'b0, vecs[i].data, vecs[i].stop_ok, 16, 1'b0);
      drive_bit(1'b0, 1'b1, 32);
      check($sformatf("v%0d_done", i), dq_a.size() - d0, vecs[i].exp_done);
      check($sformatf("v%0d_err", i), err_cnt_a - e0, vecs[i].exp_err);
      check($sformatf("v%0d_data", i), int'(data_a), vecs[i].exp_data);
      if (vecs[i].exp_done != 0 && dq_a.size() > d0)
        check($sformatf("v%0d_lat", i), lq_a[d0], vecs[i].exp_lat);
      if (vecs[i].exp_err != 0)
        check($sformatf("v%0d_err_lat", i), err_lat_a, vecs[i].exp_lat);
    end

    // Back-to-back frames with no idle gap.
    d0 = dq_a.size();
    e0 = err_cnt_a;
    send_frame(1'b0, 8'h00, 1'b1, 16, 1'b0);
    send_frame(1'b0, 8'hFF, 1'b1, 16, 1'b1);
    drive_bit(1'b0, 1'b1, 32);
    check("b2b_count", dq_a.size() - d0, 2);
    check("b2b_err", err_cnt_a - e0, 0);
    if (dq_a.size() >= d0 + 2) begin
      check("b2b_first", int'(dq_a[d0]), 8'h00);
      check("b2b_second", int'(dq_a[d0 + 1]), 8'hFF);
      check("b2b_second_lat", lq_a[d0 + 1], 152);
    end

    // Short low glitch followed by a real frame.
    d0 = dq_a.size();
    e0 = err_cnt_a;
    align();
    drive_bit(1'b0, 1'b0, 4);
    drive_bit(1'b0, 1'b1, 20);
    check("glitch_no_done", dq_a.size() - d0, 0);
    check("glitch_no_err", err_cnt_a - e0, 0);
    send_frame(1'b0, 8'h3C, 1'b1, 16, 1'b0);
    drive_bit(1'b0, 1'b1, 32);
    check("glitch_done", dq_a.size() - d0, 1);
    check("glitch_data", int'(data_a), 8'h3C);
    check("glitch_err", err_cnt_a - e0, 0);

    // Reset in the middle of data bit 4 of 0xC3.
    d0 = dq_a.size();
    e0 = err_cnt_a;
    c3 = 8'hC3;
    align();
    mark_start(1'b0);
    drive_bit(1'b0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, c3[i], 16);
    drive_bit(1'b0, c3[4], 8);
    i_rst_n = 1'b0;
    rx_a    = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_data", int'(data_a), 0);
    check("rst_mid_done", int'(done_a), 0);
    check("rst_mid_err", int'(err_a), 0);
    i_rst_n = 1'b1;
    drive_bit(1'b0, 1'b1, 16);
    drive_bit(1'b0, 1'b1, 160);
    check("rst_no_done", dq_a.size() - d0, 0);
    check("rst_no_err", err_cnt_a - e0, 0);
    send_frame(1'b0, 8'h81, 1'b1, 16, 1'b0);
    drive_bit(1'b0, 1'b1, 32);
    check("rst_after_done", dq_a.size() - d0, 1);
    check("rst_after_data", int'(data_a), 8'h81);

    // Two stop bits on the second instance, then a frame right after the 2nd stop bit.
    d0 = dq_a.size();
    d1 = dq_b.size();
    e0 = err_cnt_b;
    send_frame(1'b1, 8'h7E, 1'b1, 32, 1'b0);
    send_frame(1'b1, 8'h5A, 1'b1, 32, 1'b1);
    drive_bit(1'b1, 1'b1, 32);
    check("stop2_count", dq_b.size() - d1, 2);
    check("stop2_err", err_cnt_b - e0, 0);
    if (dq_b.size() >= d1 + 2) begin
      check("stop2_first", int'(dq_b[d1]), 8'h7E);
      check("stop2_first_lat", lq_b[d1], 168);
      check("stop2_second", int'(dq_b[d1 + 1]), 8'h5A);
    end
    check("stop2_data_held", int'(data_b), 8'h5A);
    check("stop2_other_quiet", dq_a.size() - d0, 0);

    check("pulse_exclusive", excl_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
